// File: rtl/hazard_pkg.sv
// Shared opcode constants, branch FSM state and load scoreboard entry type for hazard_ctrl.
// Scoreboard entries hold specifiers zero-extended to SB_RD_W bits, so REG_W must not exceed SB_RD_W.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE     = 6'h00;
    localparam logic [2:0] OP_STORE_PFX = 3'b101;
    localparam logic [5:0] OP_BR_LO     = 6'h04;
    localparam logic [5:0] OP_BR_HI     = 6'h07;

    localparam int SB_RD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    typedef struct packed {
        logic               vld;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op >= OP_BR_LO) && (op <= OP_BR_HI);
    endfunction

endpackage

// File: rtl/hazard_ctrl_load_scoreboard.sv
// Shift register of in-flight loads; flags a source that matches a load whose result is not yet forwardable.
// One entry per load-use cycle; entry 0 is the youngest, the last entry retires and is forwardable.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W    = 6,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ins_vld_i,
    input  logic [REG_W-1:0] ins_rd_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    output logic             match1_o,
    output logic             match2_o
);

    sb_entry_t ent_q [LOAD_LAT];
    sb_entry_t ent_d [LOAD_LAT];

    always_comb begin
        ent_d[0].vld = ins_vld_i;
        ent_d[0].rd  = ins_vld_i ? SB_RD_W'(ins_rd_i) : '0;
        for (int i = 1; i < LOAD_LAT; i++) begin
            ent_d[i] = ent_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // The oldest entry retires this cycle and its result is bypassed, so it never matches.
    always_comb begin
        match1_o = 1'b0;
        match2_o = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (ent_q[i].vld && (i != LOAD_LAT - 1)) begin
                if (ent_q[i].rd == SB_RD_W'(src1_i)) match1_o = 1'b1;
                if (ent_q[i].rd == SB_RD_W'(src2_i)) match2_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Fetch/decode hazard controller: load-use stall/bubble via a load scoreboard, branch flush FSM; outputs are combinational.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W      = 6,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [5:0]       fetch_op,
    input  logic [REG_W-1:0] fetch_rs1,
    input  logic [REG_W-1:0] fetch_rs2,
    input  logic             decode_valid,
    input  logic             decode_is_load,
    input  logic [REG_W-1:0] decode_rd,
    input  logic             exec_branch_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      flush_count
`endif
);

    localparam logic [1:0] CNT_LOAD = (BR_PENALTY > 1) ? 2'(BR_PENALTY - 2) : 2'd0;

    br_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       flush_raw;
    logic       uses_rs2;
    logic       dec_load;
    logic       sb_match1, sb_match2;
    logic       hit1, hit2;
    logic       load_haz;
    logic       sb_ins_vld;

    assign uses_rs2 = (fetch_op == OP_RTYPE) || (fetch_op[5:3] == OP_STORE_PFX);
    assign dec_load = decode_valid && decode_is_load;

    assign hit1 = (fetch_rs1 != '0) &&
                  ((dec_load && (decode_rd == fetch_rs1)) || sb_match1);
    assign hit2 = uses_rs2 && (fetch_rs2 != '0) &&
                  ((dec_load && (decode_rd == fetch_rs2)) || sb_match2);
    assign load_haz = fetch_valid && (hit1 || hit2);

    // Flush wins over stall; reset forces every control output low.
    assign flush  = flush_raw && !reset;
    assign stall  = load_haz && !flush && !reset;
    assign bubble = stall;

    assign sb_ins_vld = dec_load && !flush && (decode_rd != '0);

    load_scoreboard #(
        .REG_W    (REG_W),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk_i     (clk),
        .reset_i   (reset),
        .ins_vld_i (sb_ins_vld),
        .ins_rd_i  (decode_rd),
        .src1_i    (fetch_rs1),
        .src2_i    (fetch_rs2),
        .match1_o  (sb_match1),
        .match2_o  (sb_match2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Branches resolving while in FLUSH belong to squashed instructions and are ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (exec_branch_taken) begin
                    flush_raw = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            FLUSH: begin
                flush_raw = 1'b1;
                if (cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller between fetch and decode. It replaces single-cycle combinational load/branch bubble detection with a registered load scoreboard covering a configurable load-use latency. It also adds a branch-flush state machine with a configurable misprediction penalty. It drives stall, bubble and flush to the fetch/decode pipeline registers.

## Interface
Parameters:
- REG_W, 6, register specifier width
- LOAD_LAT, 1, cycles after decode during which a load result is unavailable (1..4)
- BR_PENALTY, 1, flush cycles per taken branch (1..4)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- fetch_valid  in  1  fetch register holds a real instruction
- fetch_op  in  [0:5]  opcode in fetch
- fetch_rs1, fetch_rs2  in  [0:REG_W-1]  source specifiers in fetch
- decode_valid  in  1  decode register holds a real instruction
- decode_is_load  in  1  decode instruction is a load
- decode_rd  in  [0:REG_W-1]  destination in decode
- exec_branch_taken  in  1  branch in execute resolved taken this cycle
- stall  out  1  hold PC and fetch register
- bubble  out  1  load nop into decode register
- flush  out  1  squash fetch and decode registers
- stall_count, flush_count  out  [0:31]  present only with HAZARD_PERF_EN

## Operation
- Operand use: rs1 is always read; rs2 is read when fetch_op == 6'h00 (R-type) or fetch_op[0:2] == 3'b101 (store). Specifier 0 never causes a hazard.
- Scoreboard: LOAD_LAT entries of {valid, rd}. Every cycle, entry[i+1] <= entry[i], and entry[LOAD_LAT-1] retires.
- Scoreboard insertion: entry[0] <= {1, decode_rd} when decode_valid & decode_is_load & !flush & decode_rd != 0. Otherwise entry[0] <= invalid.
- Scoreboard shifting continues during stall because the bubble advances down the pipeline.
- Load hazard: fetch_valid and a used source matches either (a) decode_rd while decode_valid & decode_is_load, or (b) a valid scoreboard entry other than the oldest entry when LOAD_LAT > 1.
  - The entry that retires this cycle is forwardable and is not a hazard.
- stall = bubble = load hazard & !flush.
- Branch FSM, states IDLE and FLUSH, with a down-counter of width 2:
  - IDLE: exec_branch_taken sets flush = 1 combinationally. If BR_PENALTY > 1, load the counter with BR_PENALTY-2 and go to FLUSH; otherwise stay in IDLE.
  - FLUSH: flush = 1. Return to IDLE when the counter is 0; otherwise decrement.
  - exec_branch_taken is ignored in FLUSH, because squashed instructions cannot resolve.
- Priority: flush over stall. While flush is high, stall and bubble are 0 and no scoreboard insertion occurs.

## Timing
- stall, bubble and flush are combinational from current inputs and registered state, and are valid in the same cycle.
- Scoreboard and FSM update on the rising edge of clk.
- Reset: all scoreboard entries invalid, FSM in IDLE, counter 0, perf counters 0.
  - During any cycle with reset high, stall = bubble = flush = 0 regardless of inputs.
- Reset asserted mid-flush aborts the flush. The cycle after reset deasserts is IDLE with no pending loads.
- A taken branch and a load hazard in the same cycle produce flush = 1 and stall = 0.
- A load-use hazard with LOAD_LAT = L gives exactly L stall cycles for a dependent instruction immediately behind the load.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count increments on each cycle with stall = 1.
  - flush_count increments on each cycle with flush = 1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- HAZARD_PERF_EN undefined: both counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - opcode constants OP_RTYPE = 6'h00, OP_STORE_PFX = 3'b101, OP_BR_LO = 6'h04, OP_BR_HI = 6'h07
  - the FSM state type (IDLE, FLUSH)
  - the scoreboard entry typedef
- Sub-module load_scoreboard (parameters REG_W, LOAD_LAT) contains the shift register and a per-source match output.
- hazard_ctrl instantiates load_scoreboard once and contains the FSM and output logic.

## Test plan
- LOAD_LAT=1: decode load rd=5, fetch R-type rs2=5 -> stall = bubble = 1 for one cycle, then 0.
- LOAD_LAT=3: decode load rd=7, fetch rs1=7 on the next three cycles -> stall for exactly 3 cycles. A fetch with rs1=7 not immediately behind the load stalls only for the remaining count.
- Load with rd=0, or fetch store from rs2 against a non-load decode -> stall = 0.
- BR_PENALTY=3:
  - exec_branch_taken pulse -> flush high for 3 consecutive cycles.
  - A second exec_branch_taken during FLUSH does not extend the flush.
- Taken branch concurrent with a load hazard -> flush = 1 and stall = 0, and the load is not entered in the scoreboard.
- Reset asserted in the second flush cycle -> outputs 0 and state IDLE. With HAZARD_PERF_EN, stall_count and flush_count read 0 after reset and count 3/3 after the preceding scenarios rerun.
